register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_if.sv | 15 +
 rtl/register_file.sv | 83 ++++++++
 tb/tb_register_file.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file access bus: two combinational read ports, one write port.
interface register_file_if #(
  parameter int WIDTH = 32
);
  logic [4:0]       A1;
  logic [4:0]       A2;
  logic [4:0]       A3;
  logic             WE3;
  logic [WIDTH-1:0] WD3;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;

  modport master (output A1, A2, A3, WE3, WD3, input RD1, RD2);
  modport slave  (input A1, A2, A3, WE3, WD3, output RD1, RD2);
endinterface

// File: rtl/register_file.sv
// 32 x WIDTH register file, 2 async read ports, 1 sync write port.
// x0 is hardwired to zero; optional same-cycle write-to-read forwarding.

// One storage register with write strobe and async clear.
module rf_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  // Load on strobe; async clear dominates any pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module register_file #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  register_file_if.slave  bus
);
  localparam int NREG = 32;

  logic [NREG-1:0]            w_dec;
  logic [NREG-1:0]            w_we;
  logic [NREG-1:0][WIDTH-1:0] w_x;
  logic [WIDTH-1:0]           w_rd1;
  logic [WIDTH-1:0]           w_rd2;

  // One-hot decode of the write index, gated by WE3. Bit 0 is masked so
  // x0 never loads and synthesises to a constant zero.
  always_comb begin
    w_dec = '0;
    w_dec[bus.A3] = 1'b1;
    w_we  = w_dec & {NREG{bus.WE3}};
    w_we[0] = 1'b0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      rf_reg #(.WIDTH(WIDTH)) u_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_we[gi]),
        .i_d     (bus.WD3),
        .o_q     (w_x[gi])
      );
    end
  endgenerate

  // Read port 1: zero for x0 or in reset, forwarded write data when enabled.
  always_comb begin
    w_rd1 = '0;
    if (reset_n && bus.A1 != 5'd0) begin
      if (BYPASS != 0 && bus.WE3 && bus.A3 == bus.A1) w_rd1 = bus.WD3;
      else                                            w_rd1 = w_x[bus.A1];
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    w_rd2 = '0;
    if (reset_n && bus.A2 != 5'd0) begin
      if (BYPASS != 0 && bus.WE3 && bus.A3 == bus.A2) w_rd2 = bus.WD3;
      else                                            w_rd2 = w_x[bus.A2];
    end
  end

  assign bus.RD1 = w_rd1;
  assign bus.RD2 = w_rd2;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a forwarding (BYPASS=1) and a non-forwarding
// (BYPASS=0) instance share the same stimulus. Each check pushes the four
// expected read values {byp.RD1, byp.RD2, nob.RD1, nob.RD2} to a queue and
// pops them when the outputs are sampled.
module tb_register_file;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  register_file_if #(.WIDTH(W)) ifb ();
  register_file_if #(.WIDTH(W)) ifn ();

  assign ifn.A1  = ifb.A1;
  assign ifn.A2  = ifb.A2;
  assign ifn.A3  = ifb.A3;
  assign ifn.WE3 = ifb.WE3;
  assign ifn.WD3 = ifb.WD3;

  register_file #(.WIDTH(W), .BYPASS(1)) u_byp (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));
  register_file #(.WIDTH(W), .BYPASS(0)) u_nob (.clk(clk), .reset_n(reset_n), .bus(ifn.slave));

  logic [4*W-1:0] sbq[$];
  logic [4*W-1:0] e, got;
  int n_err = 0;
  int n_chk = 0;

  function automatic void sb_push(logic [W-1:0] b1, logic [W-1:0] b2,
                                  logic [W-1:0] n1, logic [W-1:0] n2);
    sbq.push_back({b1, b2, n1, n2});
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [W-1:0] d);
    ifb.A3 = a; ifb.WD3 = d; ifb.WE3 = 1'b1;
    step();
    ifb.WE3 = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ifb.A1 = 5'd3; ifb.A2 = 5'd31; ifb.A3 = 5'd3; ifb.WE3 = 1'b1; ifb.WD3 = 32'h77;
    sb_push(0, 0, 0, 0);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL reset_read: got %h want %h", got, e); end
    step();                       // edge while in reset: write ignored
    reset_n = 1'b1;
    ifb.WE3 = 1'b0;
    sb_push(0, 0, 0, 0);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL reset_write_ignored: got %h want %h", got, e); end
  endtask

  task automatic test_write_sweep();
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
    for (int i = 1; i < 32; i++) begin
      ifb.A1 = 5'(i); ifb.A2 = 5'(i);
      sb_push(32'hA5A5_0000 + 32'(i), 32'hA5A5_0000 + 32'(i),
              32'hA5A5_0000 + 32'(i), 32'hA5A5_0000 + 32'(i));
      #1;
      e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
      if (got !== e) begin n_err++; $display("FAIL sweep x%0d: got %h want %h", i, got, e); end
    end
    ifb.A1 = 5'd1; ifb.A2 = 5'd31;
    sb_push(32'hA5A5_0001, 32'hA5A5_001F, 32'hA5A5_0001, 32'hA5A5_001F);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL sweep_two_addr: got %h want %h", got, e); end
  endtask

  task automatic test_x0();
    ifb.A1 = 5'd0; ifb.A2 = 5'd0; ifb.A3 = 5'd0; ifb.WD3 = 32'hFFFF_FFFF; ifb.WE3 = 1'b1;
    sb_push(0, 0, 0, 0);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL x0_no_bypass: got %h want %h", got, e); end
    step();
    ifb.WE3 = 1'b0;
    sb_push(0, 0, 0, 0);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL x0_protect: got %h want %h", got, e); end
    ifb.A1 = 5'd1;
    sb_push(32'hA5A5_0001, 0, 32'hA5A5_0001, 0);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL x0_write_leak: got %h want %h", got, e); end
  endtask

  task automatic test_disabled_write();
    ifb.WE3 = 1'b0; ifb.A3 = 5'd7; ifb.WD3 = 32'hDEAD_BEEF;
    step();
    ifb.WD3 = 'x;
    step();
    ifb.A1 = 5'd7; ifb.A2 = 5'd7;
    sb_push(32'hA5A5_0007, 32'hA5A5_0007, 32'hA5A5_0007, 32'hA5A5_0007);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL disabled_write: got %h want %h", got, e); end
  endtask

  task automatic test_bypass();
    wr(5'd5, 32'h11);
    ifb.A1 = 5'd5; ifb.A2 = 5'd5; ifb.A3 = 5'd5; ifb.WD3 = 32'h22; ifb.WE3 = 1'b1;
    sb_push(32'h22, 32'h22, 32'h11, 32'h11);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL bypass_pre_edge: got %h want %h", got, e); end
    step();
    ifb.WE3 = 1'b0;
    sb_push(32'h22, 32'h22, 32'h22, 32'h22);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL bypass_post_edge: got %h want %h", got, e); end
    // forwarding only on the port whose address matches
    ifb.A1 = 5'd6; ifb.A2 = 5'd5; ifb.A3 = 5'd6; ifb.WD3 = 32'h66; ifb.WE3 = 1'b1;
    sb_push(32'h66, 32'h22, 32'hA5A5_0006, 32'h22);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL bypass_one_port: got %h want %h", got, e); end
    step();
    ifb.WE3 = 1'b0;
    sb_push(32'h66, 32'h22, 32'h66, 32'h22);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL bypass_one_port_post: got %h want %h", got, e); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] prev;
    for (int i = 20; i < 25; i++) begin
      prev = (i == 20) ? 32'hA5A5_0013 : 32'hB0 + 32'(i - 1);
      ifb.A1 = 5'(i - 1); ifb.A2 = 5'(i); ifb.A3 = 5'(i);
      ifb.WD3 = 32'hB0 + 32'(i); ifb.WE3 = 1'b1;
      sb_push(prev, 32'hB0 + 32'(i), prev, 32'hA5A5_0000 + 32'(i));
      #1;
      e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
      if (got !== e) begin n_err++; $display("FAIL back_to_back x%0d: got %h want %h", i, got, e); end
      step();
    end
    ifb.WE3 = 1'b0;
    ifb.A1 = 5'd24; ifb.A2 = 5'd23;
    sb_push(32'hC8, 32'hC7, 32'hC8, 32'hC7);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL back_to_back_final: got %h want %h", got, e); end
  endtask

  task automatic test_async_reset();
    wr(5'd10, 32'h1234);
    ifb.A1 = 5'd10; ifb.A2 = 5'd31;
    sb_push(32'h1234, 32'hA5A5_001F, 32'h1234, 32'hA5A5_001F);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL areset_preload: got %h want %h", got, e); end
    #1 reset_n = 1'b0;            // between edges
    sb_push(0, 0, 0, 0);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL areset_immediate: got %h want %h", got, e); end
    ifb.A3 = 5'd10; ifb.WD3 = 32'h99; ifb.WE3 = 1'b1;
    sb_push(0, 0, 0, 0);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL areset_bypass_suppressed: got %h want %h", got, e); end
    step();
    ifb.WE3 = 1'b0;
    #2 reset_n = 1'b1;
    sb_push(0, 0, 0, 0);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL areset_write_lost: got %h want %h", got, e); end
    step();
    wr(5'd10, 32'h55);
    sb_push(32'h55, 0, 32'h55, 0);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL areset_after_release: got %h want %h", got, e); end
    // reset asserted in the same cycle as a write
    ifb.A3 = 5'd12; ifb.WD3 = 32'hAB; ifb.WE3 = 1'b1;
    #2 reset_n = 1'b0;
    step();
    ifb.WE3 = 1'b0;
    reset_n = 1'b1;
    ifb.A1 = 5'd12; ifb.A2 = 5'd10;
    sb_push(0, 0, 0, 0);
    #1;
    e = sbq.pop_front(); got = {ifb.RD1, ifb.RD2, ifn.RD1, ifn.RD2}; n_chk++;
    if (got !== e) begin n_err++; $display("FAIL areset_same_cycle: got %h want %h", got, e); end
  endtask

  initial begin
    ifb.A1 = '0; ifb.A2 = '0; ifb.A3 = '0; ifb.WE3 = 1'b0; ifb.WD3 = '0;
    test_reset();
    test_write_sweep();
    test_x0();
    test_disabled_write();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
